// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared types, defaults and saturation helpers for fc_layer_engine
//
// Purpose : FSM state encoding, default layer sizes, counter-width and
//           saturation-bound helpers shared by fc_layer_engine and fc_mac_unit.
// Ports   : none (package).

package fc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LD_IN,
      ST_MAC,
      ST_BIAS,
      ST_RES,
      ST_WRITE,
      ST_DONE
   } fc_state_e;

   localparam int NUM_IN_DEF  = 400;
   localparam int NUM_OUT_DEF = 120;

   // Counter width for an index range 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Largest / smallest value of a w-bit signed number, in 64-bit signed form.
   function automatic logic signed [63:0] sat_hi(input int w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] sat_lo(input int w);
      return -(64'sd1 <<< (w - 1));
   endfunction

   function automatic logic signed [63:0] clamp(input logic signed [63:0] v,
                                                input logic signed [63:0] lo,
                                                input logic signed [63:0] hi);
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/fc_layer_engine_if.sv
// rtl/fc_layer_engine_if.sv - DRAM read/write port bundle of fc_layer_engine
//
// Purpose : groups the DRAM request/response signals.
// Ports   : master = engine side (drives addr_in, dram_en_rd, addr_out,
//           data_out, dram_en_wr; receives dram_valid, data_in);
//           slave  = memory side (mirror image).

interface fc_layer_engine_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 18
);
   logic                  dram_valid;
   logic [DATA_WIDTH-1:0] data_in;
   logic [ADDR_WIDTH-1:0] addr_in;
   logic                  dram_en_rd;
   logic [ADDR_WIDTH-1:0] addr_out;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  dram_en_wr;

   modport master (
      input  dram_valid, data_in,
      output addr_in, dram_en_rd, addr_out, data_out, dram_en_wr
   );

   modport slave (
      output dram_valid, data_in,
      input  addr_in, dram_en_rd, addr_out, data_out, dram_en_wr
   );
endinterface

// File: rtl/fc_mac_unit.sv
// rtl/fc_mac_unit.sv - multiply, guarded saturating accumulate, bias, saturate, ReLU
//
// Purpose : datapath of one FC output neuron. Optional macro FC_RELU_EN
//           clamps negative results to zero.
// Ports   : clk, srstn      clock, async active-low reset
//           clear           zero the accumulator
//           acc_en          accumulate weight_i * act_i
//           bias_en         latch saturate(acc + bias_i) into result_o, zero acc
//           weight_i/act_i  multiplicands; bias_i bias word
//           result_o        registered layer output

module fc_mac_unit
   import fc_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int FRAC_BITS  = 16,
   parameter int GUARD_BITS = 8
) (
   input  logic                  clk,
   input  logic                  srstn,
   input  logic                  clear,
   input  logic                  acc_en,
   input  logic                  bias_en,
   input  logic [DATA_WIDTH-1:0] weight_i,
   input  logic [DATA_WIDTH-1:0] act_i,
   input  logic [DATA_WIDTH-1:0] bias_i,
   output logic [DATA_WIDTH-1:0] result_o
);

   localparam int AW = DATA_WIDTH + GUARD_BITS;
   localparam int PW = 2 * DATA_WIDTH;

   localparam logic signed [63:0] ACC_HI = sat_hi(AW);
   localparam logic signed [63:0] ACC_LO = sat_lo(AW);
   localparam logic signed [63:0] OUT_HI = sat_hi(DATA_WIDTH);
   localparam logic signed [63:0] OUT_LO = sat_lo(DATA_WIDTH);

   logic signed [PW-1:0]  prod_full;
   logic signed [PW-1:0]  prod_sh;
   logic signed [63:0]    prod_c;
   logic signed [63:0]    acc_sum;
   logic signed [63:0]    res_sum;
   logic [DATA_WIDTH-1:0] res_sat;
   logic signed [AW-1:0]  acc_q, acc_d;
   logic [DATA_WIDTH-1:0] res_q, res_d;

   always_comb begin
      prod_full = PW'($signed(weight_i)) * PW'($signed(act_i));
      prod_sh   = prod_full >>> FRAC_BITS;
      // Products and the running sum are clamped to the guarded width so a
      // large partial sum pins at the rail instead of wrapping sign.
      prod_c    = clamp(64'(prod_sh), ACC_LO, ACC_HI);
      acc_sum   = clamp(64'(acc_q) + prod_c, ACC_LO, ACC_HI);
      acc_d     = AW'(acc_sum);
      res_sum   = clamp(64'(acc_q) + 64'($signed(bias_i)), OUT_LO, OUT_HI);
      res_sat   = DATA_WIDTH'(res_sum);
`ifdef FC_RELU_EN
      res_d     = res_sat[DATA_WIDTH-1] ? '0 : res_sat;
`else
      res_d     = res_sat;
`endif
   end

   always_ff @(posedge clk or negedge srstn) begin
      if (!srstn) begin
         acc_q <= '0;
         res_q <= '0;
      end else begin
         if (clear || bias_en) begin
            acc_q <= '0;
         end else if (acc_en) begin
            acc_q <= acc_d;
         end
         if (bias_en) begin
            res_q <= res_d;
         end
      end
   end

   assign result_o = res_q;

endmodule

// File: rtl/fc_layer_engine.sv
// rtl/fc_layer_engine.sv - streaming fully-connected layer engine (top)
//
// Purpose : loads NUM_IN inputs into a local buffer, then for each of NUM_OUT
//           outputs streams a weight row, adds bias, saturates and writes the
//           result. Optional macro FC_RELU_EN (in fc_mac_unit) enables ReLU.
// Ports   : clk, srstn  clock, async active-low reset
//           enable      start pulse, honoured only in IDLE
//           dram        fc_layer_engine_if.master DRAM request/response bundle
//           busy        high outside IDLE
//           done        one-cycle completion pulse

module fc_layer_engine
   import fc_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int FRAC_BITS  = 16,
   parameter int ADDR_WIDTH = 18,
   parameter int NUM_IN     = NUM_IN_DEF,
   parameter int NUM_OUT    = NUM_OUT_DEF,
   parameter int GUARD_BITS = 8,
   parameter int IFMAP_BASE = 65536,
   parameter int WT_BASE    = 0,
   parameter int BS_BASE    = 48000,
   parameter int OFMAP_BASE = 131072
) (
   input  logic                clk,
   input  logic                srstn,
   input  logic                enable,
   fc_layer_engine_if.master   dram,
   output logic                busy,
   output logic                done
);

   localparam int IW = cnt_width(NUM_IN);
   localparam int OW = cnt_width(NUM_OUT);
   localparam logic [IW-1:0] I_LAST = IW'(NUM_IN - 1);
   localparam logic [OW-1:0] O_LAST = OW'(NUM_OUT - 1);

   fc_state_e             state_q, state_d;
   logic [IW-1:0]         i_q, i_d;
   logic [OW-1:0]         o_q, o_d;
   logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
   logic                  in_vld_q, in_vld_d;
   logic                  wt_vld_q, wt_vld_d;
   logic [IW-1:0]         in_idx_q, wt_idx_q;

   logic                  rd_en, wr_en;
   logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;
   logic                  mac_clear, mac_bias;
   logic [DATA_WIDTH-1:0] ifmap_buf [NUM_IN];
   logic [DATA_WIDTH-1:0] mac_result;

   always_comb begin
      state_d   = state_q;
      i_d       = i_q;
      o_d       = o_q;
      wptr_d    = wptr_q;
      rd_en     = 1'b0;
      wr_en     = 1'b0;
      rd_addr   = '0;
      wr_addr   = '0;
      in_vld_d  = 1'b0;
      wt_vld_d  = 1'b0;
      mac_clear = 1'b0;
      mac_bias  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            mac_clear = 1'b1;
            if (enable) begin
               state_d = ST_LD_IN;
               i_d     = '0;
               o_d     = '0;
               wptr_d  = '0;
            end
         end
         ST_LD_IN: begin
            rd_en   = 1'b1;
            rd_addr = ADDR_WIDTH'(IFMAP_BASE) + ADDR_WIDTH'(i_q);
            if (dram.dram_valid) begin
               in_vld_d = 1'b1;
               if (i_q == I_LAST) begin
                  i_d     = '0;
                  state_d = ST_MAC;
               end else begin
                  i_d = i_q + 1'b1;
               end
            end
         end
         ST_MAC: begin
            // Rows are contiguous, so a running pointer equals o*NUM_IN+i.
            rd_en   = 1'b1;
            rd_addr = ADDR_WIDTH'(WT_BASE) + wptr_q;
            if (dram.dram_valid) begin
               wt_vld_d = 1'b1;
               wptr_d   = wptr_q + 1'b1;
               if (i_q == I_LAST) begin
                  i_d     = '0;
                  state_d = ST_BIAS;
               end else begin
                  i_d = i_q + 1'b1;
               end
            end
         end
         ST_BIAS: begin
            rd_en   = 1'b1;
            rd_addr = ADDR_WIDTH'(BS_BASE) + ADDR_WIDTH'(o_q);
            if (dram.dram_valid) begin
               state_d = ST_RES;
            end
         end
         ST_RES: begin
            // Bias read was accepted on the previous edge, so data_in is the bias.
            mac_bias = 1'b1;
            state_d  = ST_WRITE;
         end
         ST_WRITE: begin
            wr_en   = 1'b1;
            wr_addr = ADDR_WIDTH'(OFMAP_BASE) + ADDR_WIDTH'(o_q);
            if (dram.dram_valid) begin
               if (o_q == O_LAST) begin
                  state_d = ST_DONE;
               end else begin
                  o_d     = o_q + 1'b1;
                  state_d = ST_MAC;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge srstn) begin
      if (!srstn) begin
         state_q  <= ST_IDLE;
         i_q      <= '0;
         o_q      <= '0;
         wptr_q   <= '0;
         in_vld_q <= 1'b0;
         wt_vld_q <= 1'b0;
         in_idx_q <= '0;
         wt_idx_q <= '0;
      end else begin
         state_q  <= state_d;
         i_q      <= i_d;
         o_q      <= o_d;
         wptr_q   <= wptr_d;
         in_vld_q <= in_vld_d;
         wt_vld_q <= wt_vld_d;
         // Read data returns one cycle after acceptance; remember its index.
         in_idx_q <= i_q;
         wt_idx_q <= i_q;
      end
   end

   always_ff @(posedge clk) begin
      if (in_vld_q) begin
         ifmap_buf[in_idx_q] <= dram.data_in;
      end
   end

   fc_mac_unit #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_BITS  (FRAC_BITS),
      .GUARD_BITS (GUARD_BITS)
   ) u_mac (
      .clk      (clk),
      .srstn    (srstn),
      .clear    (mac_clear),
      .acc_en   (wt_vld_q),
      .bias_en  (mac_bias),
      .weight_i (dram.data_in),
      .act_i    (ifmap_buf[wt_idx_q]),
      .bias_i   (dram.data_in),
      .result_o (mac_result)
   );

   assign dram.dram_en_rd = rd_en;
   assign dram.addr_in    = rd_addr;
   assign dram.dram_en_wr = wr_en;
   assign dram.addr_out   = wr_addr;
   assign dram.data_out   = mac_result;
   assign busy            = (state_q != ST_IDLE);
   assign done            = (state_q == ST_DONE);

endmodule

// File: tb/tb_fc_layer_engine.sv
// tb/tb_fc_layer_engine.sv - scoreboard testbench for fc_layer_engine (NUM_IN=4, NUM_OUT=2)

module tb_fc_layer_engine;

   localparam int DW = 32;
   localparam int AW = 18;
   localparam int NI = 4;
   localparam int NO = 2;
   localparam int IFMAP_BASE = 65536;
   localparam int WT_BASE    = 0;
   localparam int BS_BASE    = 48000;
   localparam int OFMAP_BASE = 131072;

`ifdef FC_RELU_EN
   localparam logic [31:0] EXP_NEG_BIAS = 32'h0000_0000;
   localparam logic [31:0] EXP_NEG_SAT  = 32'h0000_0000;
`else
   localparam logic [31:0] EXP_NEG_BIAS = 32'hFFFF_0000;
   localparam logic [31:0] EXP_NEG_SAT  = 32'h8000_0000;
`endif

   logic clk;
   logic srstn;
   logic enable;
   logic busy;
   logic done;

   fc_layer_engine_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dram ();

   fc_layer_engine #(
      .DATA_WIDTH (DW),
      .FRAC_BITS  (16),
      .ADDR_WIDTH (AW),
      .NUM_IN     (NI),
      .NUM_OUT    (NO),
      .GUARD_BITS (8),
      .IFMAP_BASE (IFMAP_BASE),
      .WT_BASE    (WT_BASE),
      .BS_BASE    (BS_BASE),
      .OFMAP_BASE (OFMAP_BASE)
   ) u_dut (
      .clk    (clk),
      .srstn  (srstn),
      .enable (enable),
      .dram   (dram),
      .busy   (busy),
      .done   (done)
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   wr_t         exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] mem [int];
   logic [31:0] xv [NI];
   logic [31:0] wv [NI*NO];
   logic [31:0] bv [NO];
   int          mac_stall = 0;
   int          wr_stall = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic load();
      mem.delete();
      for (int i = 0; i < NI; i++) mem[IFMAP_BASE + i] = xv[i];
      for (int k = 0; k < NI*NO; k++) mem[WT_BASE + k] = wv[k];
      for (int o = 0; o < NO; o++) mem[BS_BASE + o] = bv[o];
   endtask

   task automatic push_exp(input int o, input logic [31:0] v);
      wr_t e;
      e.addr = AW'(OFMAP_BASE + o);
      e.data = v;
      exp_q.push_back(e);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_busy"},    64'(busy),            64'(0));
      check({tag, "_done"},    64'(done),            64'(0));
      check({tag, "_en_rd"},   64'(dram.dram_en_rd), 64'(0));
      check({tag, "_en_wr"},   64'(dram.dram_en_wr), 64'(0));
      check({tag, "_addr_in"}, 64'(dram.addr_in),    64'(0));
      check({tag, "_addr_out"},64'(dram.addr_out),   64'(0));
      check({tag, "_data_out"},64'(dram.data_out),   64'(0));
   endtask

   // Start one layer pass and measure cycles from the enable cycle to done.
   task automatic run(input string nm, input int exp_cyc, input bit poke);
      int cyc = 0;
      bit seen = 1'b0;
      @(posedge clk); #1;
      enable = 1'b1;
      while (!seen && cyc < 300) begin
         @(posedge clk); #1;
         cyc++;
         enable = (poke && (cyc == 3 || cyc == 12)) ? 1'b1 : 1'b0;
         seen = done;
      end
      check({nm, "_cycles"}, 64'(cyc), 64'(exp_cyc));
      @(posedge clk); #1;
      check({nm, "_done_pulse"}, 64'(done), 64'(0));
      check({nm, "_idle"},       64'(busy), 64'(0));
   endtask

   task automatic drain(input string nm, input int cycles);
      repeat (cycles) @(posedge clk);
      #1;
      check({nm, "_pending"}, 64'(exp_q.size()), 64'(0));
   endtask

   // DRAM model: decides dram_valid per cycle, returns read data one cycle later.
   initial begin
      bit          v;
      bit          rd_acc;
      bit          prev_rd_stall = 1'b0;
      bit          prev_wr_stall = 1'b0;
      logic [AW-1:0] a;
      dram.dram_valid = 1'b0;
      dram.data_in    = '0;
      forever begin
         @(negedge clk);
         if (prev_rd_stall) begin
            check("stall_rd_en",   64'(dram.dram_en_rd), 64'(1));
            check("stall_rd_addr", 64'(dram.addr_in),    64'(WT_BASE + 2));
         end
         if (prev_wr_stall) begin
            check("stall_wr_en",   64'(dram.dram_en_wr), 64'(1));
            check("stall_wr_addr", 64'(dram.addr_out),   64'(OFMAP_BASE));
            check("stall_wr_data", 64'(dram.data_out),   64'(32'h0001_0000));
         end
         v = 1'b1;
         prev_rd_stall = 1'b0;
         prev_wr_stall = 1'b0;
         if (dram.dram_en_rd && dram.addr_in == AW'(WT_BASE + 2) && mac_stall > 0) begin
            v = 1'b0;
            mac_stall--;
            prev_rd_stall = 1'b1;
         end
         if (dram.dram_en_wr && wr_stall > 0) begin
            v = 1'b0;
            wr_stall--;
            prev_wr_stall = 1'b1;
         end
         dram.dram_valid = v;
         rd_acc = dram.dram_en_rd && v;
         a = dram.addr_in;
         @(posedge clk); #1;
         if (rd_acc && mem.exists(int'(a))) dram.data_in = mem[int'(a)];
         else dram.data_in = 32'hDEAD_BEEF;
      end
   end

   // Monitor: every accepted write is checked against the scoreboard head.
   initial begin
      wr_t e;
      forever begin
         @(negedge clk); #2;
         if (srstn && dram.dram_en_wr && dram.dram_valid) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, required no write",
                        dram.addr_out, dram.data_out);
            end else begin
               e = exp_q.pop_front();
               check("wr_addr", 64'(dram.addr_out), 64'(e.addr));
               check("wr_data", 64'(dram.data_out), 64'(e.data));
            end
         end
      end
   end

   initial begin
      int k;
      srstn  = 1'b0;
      enable = 1'b0;
      #12;
      check_zero_outputs("rst");
      @(posedge clk); #1;
      srstn = 1'b1;

      // 1.0 * 0.5 summed over 4 = 2.0, bias -1.0 -> 1.0
      xv = '{default: 32'h0001_0000};
      wv = '{default: 32'h0000_8000};
      bv = '{default: 32'hFFFF_0000};
      load();
      push_exp(0, 32'h0001_0000);
      push_exp(1, 32'h0001_0000);
      run("basic", 19, 1'b0);
      drain("basic", 2);

      // Distinct values per index: out0 = 1*1 + 0.5 = 1.5, out1 = 0.25*1 + 1*4 - 0.25 = 4.0
      xv = '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000};
      wv = '{32'h0001_0000, 32'h0, 32'h0, 32'h0,
             32'h0000_4000, 32'h0, 32'h0, 32'h0001_0000};
      bv = '{32'h0000_8000, 32'hFFFF_C000};
      load();
      push_exp(0, 32'h0001_8000);
      push_exp(1, 32'h0004_0000);
      run("pattern", 19, 1'b0);
      drain("pattern", 2);

      // 2.0 - 3.0 = -1.0
      xv = '{default: 32'h0001_0000};
      wv = '{default: 32'h0000_8000};
      bv = '{default: 32'hFFFD_0000};
      load();
      push_exp(0, EXP_NEG_BIAS);
      push_exp(1, EXP_NEG_BIAS);
      run("negbias", 19, 1'b0);
      drain("negbias", 2);

      // Huge positive products saturate, no wrap
      xv = '{default: 32'h7FFF_0000};
      wv = '{default: 32'h7FFF_0000};
      bv = '{default: 32'h0};
      load();
      push_exp(0, 32'h7FFF_FFFF);
      push_exp(1, 32'h7FFF_FFFF);
      run("satpos", 19, 1'b0);
      drain("satpos", 2);

      // Negated weights saturate to the negative rail
      wv = '{default: 32'h8001_0000};
      load();
      push_exp(0, EXP_NEG_SAT);
      push_exp(1, EXP_NEG_SAT);
      run("satneg", 19, 1'b0);
      drain("satneg", 2);

      // Stalls: 3 cycles at MAC i=2, 2 cycles in the first WRITE
      xv = '{default: 32'h0001_0000};
      wv = '{default: 32'h0000_8000};
      bv = '{default: 32'hFFFF_0000};
      load();
      mac_stall = 3;
      wr_stall  = 2;
      push_exp(0, 32'h0001_0000);
      push_exp(1, 32'h0001_0000);
      run("stall", 24, 1'b0);
      drain("stall", 2);
      check("stall_consumed", 64'(mac_stall + wr_stall), 64'(0));

      // Reset mid-MAC with a partial sum in the accumulator
      @(posedge clk); #1;
      enable = 1'b1;
      @(posedge clk); #1;
      enable = 1'b0;
      k = 0;
      while (!(dram.dram_en_rd && dram.addr_in == AW'(WT_BASE + 3)) && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      check("reach_mac", 64'(k < 50), 64'(1));
      #2;
      srstn = 1'b0;
      #1;
      check_zero_outputs("midrst");
      @(posedge clk);
      @(posedge clk); #1;
      srstn = 1'b1;
      push_exp(0, 32'h0001_0000);
      push_exp(1, 32'h0001_0000);
      run("afterrst", 19, 1'b0);
      drain("afterrst", 2);

      // enable pulses while busy are ignored: exactly NUM_OUT writes
      push_exp(0, 32'h0001_0000);
      push_exp(1, 32'h0001_0000);
      run("busyen", 19, 1'b1);
      drain("busyen", 30);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
